// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register.
// Captures the decoded operands, register indices and control bits coming from ID,
// and registers the 3-bit ALU operation code used by EX.
// Stall holds the stage, flush inserts a bubble, and reset empties the stage.
module id_ex_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] RS1data_i,
  input  logic [DATA_W-1:0] RS2data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [REG_AW-1:0] RS1addr_i,
  input  logic [REG_AW-1:0] RS2addr_i,
  input  logic [REG_AW-1:0] RDaddr_i,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        ALUOpClass_i,
  input  logic              ALUSrc_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              MemtoReg_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] Data1_o,
  output logic [DATA_W-1:0] Data2_o,
  output logic [DATA_W-1:0] RS2data_o,
  output logic [REG_AW-1:0] RS1addr_o,
  output logic [REG_AW-1:0] RS2addr_o,
  output logic [REG_AW-1:0] RDaddr_o,
  output logic [2:0]        ALUCtrl_o,
  output logic              illegal_o,
  output logic              RegWrite_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              MemtoReg_o
);

  localparam logic [2:0] AluOr  = 3'd0;
  localparam logic [2:0] AluAnd = 3'd1;
  localparam logic [2:0] AluAdd = 3'd2;
  localparam logic [2:0] AluSub = 3'd3;
  localparam logic [2:0] AluMul = 3'd4;

  logic [2:0]        w_alu_ctrl;
  logic              w_illegal;
  logic [DATA_W-1:0] w_data2;

  logic              r_valid;
  logic [DATA_W-1:0] r_data1;
  logic [DATA_W-1:0] r_data2;
  logic [DATA_W-1:0] r_rs2data;
  logic [REG_AW-1:0] r_rs1addr;
  logic [REG_AW-1:0] r_rs2addr;
  logic [REG_AW-1:0] r_rdaddr;
  logic [2:0]        r_alu_ctrl;
  logic              r_illegal;
  logic              r_regwrite;
  logic              r_memread;
  logic              r_memwrite;
  logic              r_memtoreg;

  assign w_data2 = ALUSrc_i ? imm_i : RS2data_i;

  // Decode ALU op class + funct fields; unsupported encodings fall back to ADD and flag illegal.
  always_comb begin
    w_alu_ctrl = AluAdd;
    w_illegal  = 1'b0;
    unique case (ALUOpClass_i)
      2'b00: w_alu_ctrl = AluAdd;
      2'b01: w_alu_ctrl = AluSub;
      2'b10: begin
        if (funct7_i == 7'b0000001 && funct3_i == 3'b000) begin
          w_alu_ctrl = AluMul;
        end else if (funct7_i == 7'b0100000 && funct3_i == 3'b000) begin
          w_alu_ctrl = AluSub;
        end else if (funct7_i == 7'b0000000 && funct3_i == 3'b000) begin
          w_alu_ctrl = AluAdd;
        end else if (funct7_i == 7'b0000000 && funct3_i == 3'b111) begin
          w_alu_ctrl = AluAnd;
        end else if (funct7_i == 7'b0000000 && funct3_i == 3'b110) begin
          w_alu_ctrl = AluOr;
        end else begin
          w_alu_ctrl = AluAdd;
          w_illegal  = 1'b1;
        end
      end
      2'b11: begin
        case (funct3_i)
          3'b000:  w_alu_ctrl = AluAdd;
          3'b111:  w_alu_ctrl = AluAnd;
          3'b110:  w_alu_ctrl = AluOr;
          default: begin
            w_alu_ctrl = AluAdd;
            w_illegal  = 1'b1;
          end
        endcase
      end
      default: begin
        w_alu_ctrl = AluAdd;
        w_illegal  = 1'b0;
      end
    endcase
  end

  // Stage register: reset > flush > stall > load. An invalid load still captures data fields
  // but behaves as a bubble for valid, control, illegal and ALU op.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      r_valid    <= 1'b0;
      r_data1    <= '0;
      r_data2    <= '0;
      r_rs2data  <= '0;
      r_rs1addr  <= '0;
      r_rs2addr  <= '0;
      r_rdaddr   <= '0;
      r_alu_ctrl <= '0;
      r_illegal  <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
    end else if (!stall_i) begin
      r_data1    <= RS1data_i;
      r_data2    <= w_data2;
      r_rs2data  <= RS2data_i;
      r_rs1addr  <= RS1addr_i;
      r_rs2addr  <= RS2addr_i;
      r_rdaddr   <= RDaddr_i;
      r_valid    <= valid_i;
      r_alu_ctrl <= valid_i ? w_alu_ctrl : 3'd0;
      r_illegal  <= valid_i & w_illegal;
      r_regwrite <= valid_i & RegWrite_i;
      r_memread  <= valid_i & MemRead_i;
      r_memwrite <= valid_i & MemWrite_i;
      r_memtoreg <= valid_i & MemtoReg_i;
    end
  end

  assign valid_o    = r_valid;
  assign Data1_o    = r_data1;
  assign Data2_o    = r_data2;
  assign RS2data_o  = r_rs2data;
  assign RS1addr_o  = r_rs1addr;
  assign RS2addr_o  = r_rs2addr;
  assign RDaddr_o   = r_rdaddr;
  assign ALUCtrl_o  = r_alu_ctrl;
  assign illegal_o  = r_illegal;
  assign RegWrite_o = r_regwrite;
  assign MemRead_o  = r_memread;
  assign MemWrite_o = r_memwrite;
  assign MemtoReg_o = r_memtoreg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: reset, ALU decode, operand select, stall, flush, back-to-back.
module tb_id_ex_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i, stall_i, flush_i, valid_i;
  logic [31:0] RS1data_i, RS2data_i, imm_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddr_i;
  logic [6:0]  funct7_i;
  logic [2:0]  funct3_i;
  logic [1:0]  ALUOpClass_i;
  logic        ALUSrc_i, RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i;
  logic        valid_o;
  logic [31:0] Data1_o, Data2_o, RS2data_o;
  logic [4:0]  RS1addr_o, RS2addr_o, RDaddr_o;
  logic [2:0]  ALUCtrl_o;
  logic        illegal_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o;

  int n_tests = 0;
  int n_fail  = 0;

  id_ex_stage_reg #(.DATA_W(32), .REG_AW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .RS1data_i(RS1data_i), .RS2data_i(RS2data_i), .imm_i(imm_i),
    .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i), .RDaddr_i(RDaddr_i),
    .funct7_i(funct7_i), .funct3_i(funct3_i), .ALUOpClass_i(ALUOpClass_i),
    .ALUSrc_i(ALUSrc_i), .RegWrite_i(RegWrite_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .MemtoReg_i(MemtoReg_i),
    .valid_o(valid_o), .Data1_o(Data1_o), .Data2_o(Data2_o), .RS2data_o(RS2data_o),
    .RS1addr_o(RS1addr_o), .RS2addr_o(RS2addr_o), .RDaddr_o(RDaddr_o),
    .ALUCtrl_o(ALUCtrl_o), .illegal_o(illegal_o), .RegWrite_o(RegWrite_o),
    .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_op(input logic [1:0] cls, input logic [6:0] f7, input logic [2:0] f3);
    ALUOpClass_i = cls;
    funct7_i     = f7;
    funct3_i     = f3;
  endtask

  task automatic set_data(input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] im,
                          input logic src);
    RS1data_i = d1;
    RS2data_i = d2;
    imm_i     = im;
    ALUSrc_i  = src;
  endtask

  initial begin
    // Reset with every input driven high.
    rst_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1; valid_i = 1'b1;
    RS1data_i = '1; RS2data_i = '1; imm_i = '1;
    RS1addr_i = '1; RS2addr_i = '1; RDaddr_i = '1;
    funct7_i = '1; funct3_i = '1; ALUOpClass_i = '1; ALUSrc_i = 1'b1;
    RegWrite_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b1; MemtoReg_i = 1'b1;
    step();
    step();
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_data1", Data1_o, 32'd0);
    check("rst_data2", Data2_o, 32'd0);
    check("rst_rs2data", RS2data_o, 32'd0);
    check("rst_addrs", {17'd0, RS1addr_o, RS2addr_o, RDaddr_o}, 32'd0);
    check("rst_aluctrl", {29'd0, ALUCtrl_o}, 32'd0);
    check("rst_illegal", {31'd0, illegal_o}, 32'd0);
    check("rst_ctrl", {28'd0, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 32'd0);

    // Out of reset with no valid instruction.
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0; valid_i = 1'b0;
    RegWrite_i = 1'b0; MemRead_i = 1'b0; MemWrite_i = 1'b0; MemtoReg_i = 1'b0;
    step();
    check("idle_valid", {31'd0, valid_o}, 32'd0);

    // R-type decode.
    valid_i = 1'b1; RegWrite_i = 1'b1;
    RS1addr_i = 5'd1; RS2addr_i = 5'd2; RDaddr_i = 5'd3;
    set_data(32'd7, 32'd6, 32'd0, 1'b0);
    set_op(2'b10, 7'b0000001, 3'b000);
    step();
    check("mul_alu", {29'd0, ALUCtrl_o}, 32'd4);
    check("mul_d1", Data1_o, 32'd7);
    check("mul_d2", Data2_o, 32'd6);
    check("mul_ill", {31'd0, illegal_o}, 32'd0);
    check("mul_valid", {31'd0, valid_o}, 32'd1);
    check("mul_rd", {27'd0, RDaddr_o}, 32'd3);
    set_op(2'b10, 7'b0100000, 3'b000);
    step();
    check("sub_alu", {29'd0, ALUCtrl_o}, 32'd3);
    set_op(2'b10, 7'b0000000, 3'b110);
    step();
    check("or_alu", {29'd0, ALUCtrl_o}, 32'd0);
    set_op(2'b10, 7'b0000000, 3'b111);
    step();
    check("and_alu", {29'd0, ALUCtrl_o}, 32'd1);
    set_op(2'b10, 7'b0000000, 3'b001);
    step();
    check("rill_alu", {29'd0, ALUCtrl_o}, 32'd2);
    check("rill_flag", {31'd0, illegal_o}, 32'd1);
    check("rill_regwr", {31'd0, RegWrite_o}, 32'd1);

    // I-type with immediate operand B.
    set_data(32'd9, 32'h55, 32'hFFFF_FFFC, 1'b1);
    set_op(2'b11, 7'b1111111, 3'b000);
    step();
    check("imm_d2", Data2_o, 32'hFFFF_FFFC);
    check("imm_rs2", RS2data_o, 32'h55);
    check("imm_alu", {29'd0, ALUCtrl_o}, 32'd2);
    check("imm_ill", {31'd0, illegal_o}, 32'd0);
    set_op(2'b11, 7'b0, 3'b010);
    step();
    check("iill_flag", {31'd0, illegal_o}, 32'd1);
    set_op(2'b00, 7'b0, 3'b010);
    MemRead_i = 1'b1; MemtoReg_i = 1'b1;
    step();
    check("ls_alu", {29'd0, ALUCtrl_o}, 32'd2);
    check("ls_ctrl", {28'd0, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o}, 32'b1101);
    MemRead_i = 1'b0; MemtoReg_i = 1'b0;
    set_op(2'b01, 7'b0, 3'b000);
    step();
    check("br_alu", {29'd0, ALUCtrl_o}, 32'd3);

    // Stall: load A, then hold for 3 edges while B is presented.
    set_data(32'hA1, 32'hA2, 32'd0, 1'b0);
    set_op(2'b10, 7'b0000001, 3'b000);
    RDaddr_i = 5'd10; RegWrite_i = 1'b1; MemWrite_i = 1'b0;
    step();
    check("A_d1", Data1_o, 32'hA1);
    stall_i = 1'b1;
    set_data(32'hB1, 32'hB2, 32'hB3, 1'b1);
    set_op(2'b01, 7'b0, 3'b000);
    RDaddr_i = 5'd20; RegWrite_i = 1'b0; MemWrite_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_d1", Data1_o, 32'hA1);
      check("stall_alu", {29'd0, ALUCtrl_o}, 32'd4);
      check("stall_rd", {27'd0, RDaddr_o}, 32'd10);
    end
    stall_i = 1'b0;
    step();
    check("B_d1", Data1_o, 32'hB1);
    check("B_d2", Data2_o, 32'hB3);
    check("B_alu", {29'd0, ALUCtrl_o}, 32'd3);
    check("B_ctrl", {30'd0, RegWrite_o, MemWrite_o}, 32'b01);

    // Flush beats stall.
    set_data(32'hC1, 32'hC2, 32'd0, 1'b0);
    RegWrite_i = 1'b1; MemWrite_i = 1'b1;
    step();
    check("C_regwr", {31'd0, RegWrite_o}, 32'd1);
    stall_i = 1'b1; flush_i = 1'b1;
    step();
    check("fl_valid", {31'd0, valid_o}, 32'd0);
    check("fl_ctrl", {30'd0, RegWrite_o, MemWrite_o}, 32'd0);
    check("fl_d1", Data1_o, 32'd0);
    check("fl_alu", {29'd0, ALUCtrl_o}, 32'd0);
    stall_i = 1'b0; flush_i = 1'b0;

    // Reset during a stall empties the stage, which stays empty while still stalled.
    step();
    check("D_valid", {31'd0, valid_o}, 32'd1);
    stall_i = 1'b1; rst_i = 1'b0;
    step();
    check("rs_valid", {31'd0, valid_o}, 32'd0);
    check("rs_d1", Data1_o, 32'd0);
    rst_i = 1'b1;
    step();
    check("rs_hold", {31'd0, valid_o}, 32'd0);
    stall_i = 1'b0;

    // Invalid load: data captured, control squashed.
    valid_i = 1'b0; set_op(2'b10, 7'b0, 3'b001);
    set_data(32'hD1, 32'hD2, 32'd0, 1'b0);
    step();
    check("inv_valid", {31'd0, valid_o}, 32'd0);
    check("inv_d1", Data1_o, 32'hD1);
    check("inv_ctrl", {30'd0, RegWrite_o, MemWrite_o}, 32'd0);
    check("inv_ill", {31'd0, illegal_o}, 32'd0);

    // Back-to-back: ADD, SUB, MUL, OR.
    valid_i = 1'b1; MemWrite_i = 1'b0;
    set_op(2'b10, 7'b0000000, 3'b000);
    step();
    check("b2b_add", {29'd0, ALUCtrl_o}, 32'd2);
    set_op(2'b10, 7'b0100000, 3'b000);
    step();
    check("b2b_sub", {29'd0, ALUCtrl_o}, 32'd3);
    set_op(2'b10, 7'b0000001, 3'b000);
    step();
    check("b2b_mul", {29'd0, ALUCtrl_o}, 32'd4);
    set_op(2'b10, 7'b0000000, 3'b110);
    step();
    check("b2b_or", {29'd0, ALUCtrl_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
